hazard_controller: RTL and testbench

Pipeline sequencing controller for the five-stage RV core (IF/ID/EX/MEM/WB). It owns the enable and flush controls of the PC and every inter-stage register. It resolves data hazards that `forwarding_unit` cannot cover: load-use, and branch operands resolved in ID. It also holds the pipeline across multi-cycle events: the data-memory handshake, the iterative divider and instruction-fetch wait. Trap and taken-branch flushes come from here too, and a stall-cycle performance counter is maintained.

---
 rtl/hazard_controller.sv | 203 ++++++++++++++++++++
 tb/tb_hazard_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline sequencing controller for the five-stage RV core (IF/ID/EX/MEM/WB).
// Owns the PC load enable and the enable/flush pair of every inter-stage
// register. Resolves the hazards that forwarding cannot cover (load-use and
// ID-resolved branch operands), holds the pipe across multi-cycle events
// (data-memory handshake, iterative divider, instruction-fetch wait), issues
// the trap and taken-branch flushes and counts stall cycles.
//
// Ports
//   clock, reset_n            core clock (rising edge), async active-low reset
//   rs1_id, rs2_id            ID source registers
//   rs1_used_id, rs2_used_id  ID instruction actually reads that source
//   branch_id                 ID holds a branch/jalr compared in ID
//   branch_taken_id           redirect resolved in ID
//   rd_ex, rd_mem             EX / MEM destination registers
//   reg_we_ex                 EX writes rd
//   mem_read_ex, mem_read_mem EX / MEM is a load
//   zicsr_ex                  EX is a CSR op (result forwardable to ID)
//   div_op_ex                 EX holds a div/rem
//   div_done                  one-cycle pulse, divider result valid
//   dmem_req_mem, dmem_ack    MEM data access request / completion
//   imem_ack                  fetch data valid this cycle
//   trap_mem                  MEM instruction takes a trap
//   pc_en, *_en               PC and stage-register load enables
//   *_flush                   load a bubble (overrides enable-low)
//   div_start, div_abort      divider launch / kill
//   stall_count               cycles with if_id_en=0 and no IF/ID flush
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [4:0]             rs1_id,
    input  logic [4:0]             rs2_id,
    input  logic                   rs1_used_id,
    input  logic                   rs2_used_id,
    input  logic                   branch_id,
    input  logic                   branch_taken_id,
    input  logic [4:0]             rd_ex,
    input  logic [4:0]             rd_mem,
    input  logic                   reg_we_ex,
    input  logic                   mem_read_ex,
    input  logic                   mem_read_mem,
    input  logic                   zicsr_ex,
    input  logic                   div_op_ex,
    input  logic                   div_done,
    input  logic                   dmem_req_mem,
    input  logic                   dmem_ack,
    input  logic                   imem_ack,
    input  logic                   trap_mem,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   mem_wb_flush,
    output logic                   div_start,
    output logic                   div_abort,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DIV_WAIT  = 2'd1,
        DMEM_WAIT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd);
        return (rs == rd) && (rd != 5'd0);
    endfunction

    logic load_use;
    logic br_dep;
    logic data_haz;

    always_comb begin
        load_use = mem_read_ex &&
                   ((reg_match(rs1_id, rd_ex) && rs1_used_id) ||
                    (reg_match(rs2_id, rd_ex) && rs2_used_id));
        // Branch operands are compared in ID, so even an ALU result in EX is
        // too late; CSR results are the exception since they are forwarded.
        br_dep   = branch_id &&
                   ((reg_we_ex && !zicsr_ex &&
                     (reg_match(rs1_id, rd_ex) || reg_match(rs2_id, rd_ex))) ||
                    (mem_read_mem &&
                     (reg_match(rs1_id, rd_mem) || reg_match(rs2_id, rd_mem))));
        data_haz = load_use || br_dep;
    end

    // Next state and all control outputs.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        div_start    = 1'b0;
        div_abort    = 1'b0;
        state_d      = state_q;

        if (!reset_n) begin
            // Outputs follow reset immediately, without waiting for a clock.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = RUN;
        end else if (trap_mem) begin
            // Redirect to the trap vector; the trapping instruction still
            // retires into WB. Any outstanding dmem access is dropped.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            div_abort    = (state_q == DIV_WAIT);
            state_d      = RUN;
        end else if (state_q == DIV_WAIT) begin
            if (div_done) begin
                // Result is ready: let the div advance; do not relaunch it.
                state_d = RUN;
            end else begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
            end
        end else if ((state_q == DMEM_WAIT) && !dmem_ack) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else begin
            // RUN, or the dmem ack cycle which is evaluated exactly like RUN.
            state_d = RUN;
            if (dmem_req_mem && !dmem_ack) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_en    = 1'b0;
                mem_wb_flush = 1'b1;
                state_d      = DMEM_WAIT;
            end else if (div_op_ex) begin
                div_start    = 1'b1;
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                state_d      = DIV_WAIT;
            end else if (!imem_ack) begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end else if (data_haz) begin
                // A taken branch waiting on its operands is not acted on yet.
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (branch_taken_id) begin
                if_id_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!if_id_en && !if_id_flush) begin
            stall_count_d = stall_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic [4:0] rs1_id, rs2_id, rd_ex, rd_mem;
    logic       rs1_used_id, rs2_used_id, branch_id, branch_taken_id;
    logic       reg_we_ex, mem_read_ex, mem_read_mem, zicsr_ex;
    logic       div_op_ex, div_done, dmem_req_mem, dmem_ack, imem_ack, trap_mem;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        div_start, div_abort;
    logic [31:0] stall_count;

    logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush;
    logic        s_div_start, s_div_abort;
    logic [2:0]  s_stall_count;

    hazard_controller #(.COUNT_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .branch_id(branch_id), .branch_taken_id(branch_taken_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem),
        .reg_we_ex(reg_we_ex), .mem_read_ex(mem_read_ex), .mem_read_mem(mem_read_mem),
        .zicsr_ex(zicsr_ex), .div_op_ex(div_op_ex), .div_done(div_done),
        .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack), .imem_ack(imem_ack),
        .trap_mem(trap_mem),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .div_start(div_start), .div_abort(div_abort),
        .stall_count(stall_count)
    );

    // Narrow-counter copy: same stimulus, lets the wrap be observed quickly.
    hazard_controller #(.COUNT_WIDTH(3)) dut_w3 (
        .clock(clock), .reset_n(reset_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .branch_id(branch_id), .branch_taken_id(branch_taken_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem),
        .reg_we_ex(reg_we_ex), .mem_read_ex(mem_read_ex), .mem_read_mem(mem_read_mem),
        .zicsr_ex(zicsr_ex), .div_op_ex(div_op_ex), .div_done(div_done),
        .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack), .imem_ack(imem_ack),
        .trap_mem(trap_mem),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
        .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush),
        .div_start(s_div_start), .div_abort(s_div_abort),
        .stall_count(s_stall_count)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb}_en, {if_id, id_ex, ex_mem, mem_wb}_flush, div_start, div_abort
    wire [10:0] ctl   = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                         if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                         div_start, div_abort};
    wire [10:0] ctl_s = {s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en,
                         s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush,
                         s_div_start, s_div_abort};

    localparam logic [10:0] RST       = 11'b00000_1111_00;
    localparam logic [10:0] RUN_OK    = 11'b11111_0000_00;
    localparam logic [10:0] BUBBLE    = 11'b00111_0100_00;
    localparam logic [10:0] FETCH     = 11'b01111_1000_00;
    localparam logic [10:0] BR_TAKEN  = 11'b11111_1000_00;
    localparam logic [10:0] DIV_START = 11'b00011_0010_10;
    localparam logic [10:0] DIV_HOLD  = 11'b00011_0010_00;
    localparam logic [10:0] DMEM_HOLD = 11'b00000_0001_00;
    localparam logic [10:0] TRAP      = 11'b11111_1110_00;
    localparam logic [10:0] TRAP_AB   = 11'b11111_1110_01;

    logic [10:0] q_ctl[$];
    logic [31:0] q_cnt[$];
    string       q_name[$];
    logic [31:0] exp_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Next cycle: inputs change 1 ns after the rising edge, back to idle values.
    task automatic cyc();
        @(posedge clock);
        #1;
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0; rd_mem = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        branch_id = 1'b0; branch_taken_id = 1'b0;
        reg_we_ex = 1'b0; mem_read_ex = 1'b0; mem_read_mem = 1'b0; zicsr_ex = 1'b0;
        div_op_ex = 1'b0; div_done = 1'b0;
        dmem_req_mem = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b1; trap_mem = 1'b0;
    endtask

    // Queue the expected response for this cycle; the counter seen this cycle
    // reflects stalls of earlier cycles only.
    task automatic chk(input string name, input logic [10:0] e);
        if (!reset_n) exp_cnt = 32'd0;
        q_ctl.push_back(e);
        q_cnt.push_back(exp_cnt);
        q_name.push_back(name);
        if (reset_n && !e[9] && !e[5]) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic load_use_vec();
        mem_read_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; rs2_used_id = 1'b1;
    endtask

    // Monitor: sample mid-cycle, compare against the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            if (q_ctl.size() > 0) begin
                logic [10:0] e_ctl;
                logic [31:0] e_cnt;
                string       nm;
                bit          ok;
                e_ctl = q_ctl.pop_front();
                e_cnt = q_cnt.pop_front();
                nm    = q_name.pop_front();
                ok    = 1'b1;
                n_cmp++;
                if (ctl !== e_ctl) begin
                    n_bad++; ok = 1'b0;
                    $display("FAIL %s ctl: got %b want %b", nm, ctl, e_ctl);
                end
                n_cmp++;
                if (stall_count !== e_cnt) begin
                    n_bad++; ok = 1'b0;
                    $display("FAIL %s stall_count: got %0d want %0d", nm, stall_count, e_cnt);
                end
                n_cmp++;
                if (ctl_s !== e_ctl) begin
                    n_bad++; ok = 1'b0;
                    $display("FAIL %s ctl(w3): got %b want %b", nm, ctl_s, e_ctl);
                end
                n_cmp++;
                if (s_stall_count !== e_cnt[2:0]) begin
                    n_bad++; ok = 1'b0;
                    $display("FAIL %s stall_count(w3): got %0d want %0d", nm, s_stall_count, e_cnt[2:0]);
                end
                if (ok) $display("ok   %-16s ctl=%b stall_count=%0d", nm, ctl, stall_count);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_cnt = 32'd0;
        reset_n = 1'b0;
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0; rd_mem = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        branch_id = 1'b0; branch_taken_id = 1'b0;
        reg_we_ex = 1'b0; mem_read_ex = 1'b0; mem_read_mem = 1'b0; zicsr_ex = 1'b0;
        div_op_ex = 1'b0; div_done = 1'b0;
        dmem_req_mem = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b1; trap_mem = 1'b0;

        cyc(); chk("reset", RST);
        cyc(); chk("reset", RST);
        cyc(); reset_n = 1'b1; chk("idle", RUN_OK);

        // Load-use
        cyc(); load_use_vec(); chk("load_use_rs2", BUBBLE);
        cyc(); chk("idle_after_lu", RUN_OK);
        cyc(); load_use_vec(); rd_ex = 5'd0; rs2_id = 5'd0; chk("load_use_x0", RUN_OK);
        cyc(); mem_read_ex = 1'b1; rd_ex = 5'd9; rs1_id = 5'd9; chk("load_use_unused", RUN_OK);
        cyc(); mem_read_ex = 1'b1; rd_ex = 5'd9; rs1_id = 5'd9; rs1_used_id = 1'b1;
        chk("load_use_rs1", BUBBLE);

        // Branch operand dependencies
        cyc(); branch_id = 1'b1; branch_taken_id = 1'b1; reg_we_ex = 1'b1;
        rd_ex = 5'd7; rs1_id = 5'd7; chk("br_dep_ex", BUBBLE);
        cyc(); branch_id = 1'b1; branch_taken_id = 1'b1; reg_we_ex = 1'b1; zicsr_ex = 1'b1;
        rd_ex = 5'd7; rs1_id = 5'd7; chk("br_csr_fwd", BR_TAKEN);
        cyc(); branch_id = 1'b1; mem_read_mem = 1'b1; rd_mem = 5'd7; rs2_id = 5'd7;
        chk("br_dep_mem", BUBBLE);
        cyc(); branch_id = 1'b1; branch_taken_id = 1'b1; reg_we_ex = 1'b1;
        rd_ex = 5'd7; rs1_id = 5'd3; rs2_id = 5'd4; chk("br_no_dep", BR_TAKEN);

        // Fetch wait, which outranks a data hazard
        cyc(); imem_ack = 1'b0; chk("fetch_wait", FETCH);
        cyc(); imem_ack = 1'b0; load_use_vec(); chk("fetch_over_lu", FETCH);
        cyc(); div_done = 1'b1; chk("div_done_stray", RUN_OK);

        // Divider: start + 3 hold cycles frozen, then done
        cyc(); div_op_ex = 1'b1; chk("div_start", DIV_START);
        for (int i = 0; i < 3; i++) begin
            cyc(); div_op_ex = 1'b1; chk("div_hold", DIV_HOLD);
        end
        cyc(); div_op_ex = 1'b1; div_done = 1'b1; chk("div_done", RUN_OK);
        cyc(); chk("after_div", RUN_OK);

        // Data memory: 3 wait cycles, ack cycle, then a zero-wait access
        for (int i = 0; i < 3; i++) begin
            cyc(); dmem_req_mem = 1'b1; chk("dmem_wait", DMEM_HOLD);
        end
        cyc(); dmem_req_mem = 1'b1; dmem_ack = 1'b1; chk("dmem_ack", RUN_OK);
        cyc(); dmem_req_mem = 1'b1; dmem_ack = 1'b1; chk("dmem_same_cycle", RUN_OK);
        cyc(); chk("after_dmem", RUN_OK);

        // Trap during DIV_WAIT, then trap alongside a load-use
        cyc(); div_op_ex = 1'b1; chk("div_start", DIV_START);
        cyc(); div_op_ex = 1'b1; chk("div_hold", DIV_HOLD);
        cyc(); div_op_ex = 1'b1; trap_mem = 1'b1; chk("trap_in_div", TRAP_AB);
        cyc(); chk("after_trap_div", RUN_OK);
        cyc(); trap_mem = 1'b1; load_use_vec(); chk("trap_over_lu", TRAP);

        // Trap during DMEM_WAIT drops the access
        cyc(); dmem_req_mem = 1'b1; chk("dmem_wait", DMEM_HOLD);
        cyc(); dmem_req_mem = 1'b1; trap_mem = 1'b1; chk("trap_in_dmem", TRAP);
        cyc(); chk("after_trap_dmem", RUN_OK);

        // Asynchronous reset in the middle of a dmem wait, checked before any edge
        cyc(); dmem_req_mem = 1'b1; chk("dmem_wait", DMEM_HOLD);
        cyc(); dmem_req_mem = 1'b1; reset_n = 1'b0; chk("async_reset", RST);
        cyc(); reset_n = 1'b1; chk("run_after_reset", RUN_OK);
        cyc(); load_use_vec(); chk("load_use_post", BUBBLE);
        cyc(); chk("idle", RUN_OK);

        for (int i = 0; i < 5 && q_ctl.size() > 0; i++) @(posedge clock);
        n_cmp++;
        if (q_ctl.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses never checked, want 0", q_ctl.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
